// File: rtl/sample_word_unpacker_pkg.sv
// Shared types, widths and helpers for the sample word unpacker.
// Splits 64-bit sampled words into four masked 16-bit coefficients.
package sample_word_unpacker_pkg;

    localparam int unsigned NUM_WORDS_BITS = 12;
    localparam int unsigned CMD_BUF_SIZE   = 2;
    localparam int unsigned LOGQ_W         = 4;
    localparam int unsigned CMD_SIZE       = LOGQ_W + NUM_WORDS_BITS;
    localparam int unsigned COEFF_W        = 16;
    localparam int unsigned LANES          = 4;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned WORD_W         = COEFF_W * LANES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [LOGQ_W-1:0]         log_q;
        logic [NUM_WORDS_BITS-1:0] num_words;
    } cmd_t;

    // logQ of 0 encodes the full 16-bit coefficient width
    function automatic logic [COEFF_W-1:0] coeff_mask_f(input logic [LOGQ_W-1:0] log_q);
        logic [COEFF_W:0] w_full;
        w_full = (COEFF_W+1)'(1) << log_q;
        return (log_q == '0) ? '1 : COEFF_W'(w_full - (COEFF_W+1)'(1));
    endfunction

endpackage

// File: rtl/sample_word_unpacker_if.sv
// Command, word-input and coefficient-output handshakes of the sample word unpacker.
interface sample_word_unpacker_if;
    import sample_word_unpacker_pkg::*;

    cmd_t                cmd;
    logic                cmd_isReady;
    logic                cmd_canReceive;
    logic [WORD_W-1:0]   in_data;
    logic                in_isReady;
    logic                in_canReceive;
    logic                in_isLast_in;
    logic                in_isLast_out;
    logic [COEFF_W-1:0]  out_data;
    logic                out_isReady;
    logic                out_canReceive;
    logic                out_isLast;

    modport master (
        output cmd, cmd_isReady, in_data, in_isReady, in_isLast_in, out_canReceive,
        input  cmd_canReceive, in_canReceive, in_isLast_out, out_data, out_isReady, out_isLast
    );

    modport slave (
        input  cmd, cmd_isReady, in_data, in_isReady, in_isLast_in, out_canReceive,
        output cmd_canReceive, in_canReceive, in_isLast_out, out_data, out_isReady, out_isLast
    );

endinterface

// File: rtl/cmd_buffer.sv
// Small FIFO holding pending commands until the consumer loads them.
module cmd_buffer #(
    parameter int unsigned CmdSize = 16,
    parameter int unsigned BufSize = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CmdSize-1:0] i_data,
    input  logic               i_push,
    input  logic               i_pop,
    output logic [CmdSize-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned PtrW = (BufSize > 1) ? $clog2(BufSize) : 1;
    localparam int unsigned CntW = $clog2(BufSize + 1);

    logic [CmdSize-1:0] r_mem [BufSize];
    logic [PtrW-1:0]    r_wr_ptr;
    logic [PtrW-1:0]    r_rd_ptr;
    logic [CntW-1:0]    r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(BufSize - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CntW'(BufSize));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(BufSize); i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sample_word_unpacker_coeff_mask.sv
// Clears coefficient bits at and above logQ; purely combinational.
module sample_word_unpacker_coeff_mask
    import sample_word_unpacker_pkg::*;
(
    input  logic [LOGQ_W-1:0]  i_log_q,
    input  logic [COEFF_W-1:0] i_coeff,
    output logic [COEFF_W-1:0] o_coeff
);

    assign o_coeff = i_coeff & coeff_mask_f(i_log_q);

endmodule

// File: rtl/sample_word_unpacker.sv
// Unpacks commanded runs of 64-bit words into one masked 16-bit coefficient per cycle,
// refilling the word register in the same cycle lane 3 leaves to avoid bubbles.
module sample_word_unpacker
    import sample_word_unpacker_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    sample_word_unpacker_if.slave io_bus
);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [NUM_WORDS_BITS-1:0] r_words_left;
    logic [LOGQ_W-1:0]         r_log_q;
    logic [WORD_W-1:0]         r_word;
    logic                      r_valid;
    logic [LANE_W-1:0]         r_lane;
    logic                      r_rst_done;

    cmd_t                      w_cmd_head;
    logic                      w_cmd_full;
    logic                      w_cmd_empty;
    logic                      w_cmd_push;
    logic                      w_cmd_pop;
    logic                      w_load;
    logic                      w_in_can;
    logic                      w_in_last;
    logic                      w_in_xfer;
    logic                      w_out_xfer;
    logic                      w_lane3_out;
    logic                      w_out_last;
    logic [COEFF_W-1:0]        w_coeff_raw;
    logic [COEFF_W-1:0]        w_coeff_masked;
    logic                      w_unused_last;

    // Producer-side last hint carries no information here
    assign w_unused_last = io_bus.in_isLast_in;

    // Command acceptance is held off for the first cycle after reset release
    assign w_cmd_push = io_bus.cmd_isReady && io_bus.cmd_canReceive;

    cmd_buffer #(
        .CmdSize (CMD_SIZE),
        .BufSize (CMD_BUF_SIZE)
    ) u_cmd_buffer (
        .clk     (clk),
        .rst_n   (rst),
        .i_data  (io_bus.cmd),
        .i_push  (w_cmd_push),
        .i_pop   (w_cmd_pop),
        .o_data  (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty)
    );

    assign w_out_xfer  = r_valid && io_bus.out_canReceive;
    assign w_lane3_out = w_out_xfer && (r_lane == LANE_W'(LANES - 1));
    assign w_in_xfer   = io_bus.in_isReady && w_in_can;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (!w_cmd_empty) w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = (w_cmd_head.num_words == '0) ? ST_IDLE : ST_RUN;
            ST_RUN:   if (w_in_xfer && (r_words_left == NUM_WORDS_BITS'(1))) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_out_last && io_bus.out_canReceive) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_pop  = 1'b0;
        w_load     = 1'b0;
        w_in_can   = 1'b0;
        w_out_last = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_cmd_pop = 1'b1;
                w_load    = 1'b1;
            end
            ST_RUN:   w_in_can = (!r_valid || w_lane3_out) && (r_words_left != '0);
            ST_DRAIN: w_out_last = r_valid && (r_lane == LANE_W'(LANES - 1)) && (r_words_left == '0);
            default: ;
        endcase
        w_in_last = io_bus.in_isReady && w_in_can && (r_words_left == NUM_WORDS_BITS'(1));
    end

    // Word counter, logQ, word register and lane index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_words_left <= '0;
            r_log_q      <= '0;
            r_word       <= '0;
            r_valid      <= 1'b0;
            r_lane       <= '0;
            r_rst_done   <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_load) begin
                r_words_left <= w_cmd_head.num_words;
                r_log_q      <= w_cmd_head.log_q;
            end else if (w_in_xfer && (r_words_left != '0)) begin
                r_words_left <= r_words_left - NUM_WORDS_BITS'(1);
            end
            if (w_in_xfer) begin
                r_word  <= io_bus.in_data;
                r_valid <= 1'b1;
                r_lane  <= '0;
            end else if (w_lane3_out) begin
                r_valid <= 1'b0;
                r_lane  <= '0;
            end else if (w_out_xfer) begin
                r_lane  <= r_lane + LANE_W'(1);
            end
        end
    end

    assign w_coeff_raw = r_word[{r_lane, 4'b0000} +: COEFF_W];

    sample_word_unpacker_coeff_mask u_coeff_mask (
        .i_log_q (r_log_q),
        .i_coeff (w_coeff_raw),
        .o_coeff (w_coeff_masked)
    );

    assign io_bus.cmd_canReceive = !w_cmd_full && r_rst_done;
    assign io_bus.in_canReceive  = w_in_can;
    assign io_bus.in_isLast_out  = w_in_last;
    assign io_bus.out_data       = w_coeff_masked;
    assign io_bus.out_isReady    = r_valid;
    assign io_bus.out_isLast     = w_out_last;

endmodule

// File: tb/tb_sample_word_unpacker.sv
// Directed scoreboard bench for sample_word_unpacker.
module tb_sample_word_unpacker;

    typedef struct {
        logic [15:0] coeff;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sample_word_unpacker_if bus();

    sample_word_unpacker dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          in_last_cnt = 0;
    int          out_last_cnt = 0;
    int          run = 0;
    int          max_run = 0;
    logic        tb_last_word = 1'b0;
    logic        sink_toggle = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_out = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] c, input logic last);
        exp_t e;
        e.coeff = c;
        e.last  = last;
        q.push_back(e);
    endtask

    // Reference model: lane i of the word, bits at and above logQ cleared
    task automatic push_word(input logic [63:0] w, input logic [3:0] lq, input logic final_word);
        logic [15:0] m;
        m = (lq == 4'd0) ? 16'hFFFF : 16'((17'd1 << lq) - 17'd1);
        for (int i = 0; i < 4; i++) push_exp(w[16*i +: 16] & m, final_word && (i == 3));
    endtask

    task automatic send_cmd(input logic [3:0] lq, input logic [11:0] n);
        bus.cmd         = {lq, n};
        bus.cmd_isReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cmd_canReceive) begin
                @(posedge clk); #1;
                bus.cmd_isReady = 1'b0;
                return;
            end
        end
        bus.cmd_isReady = 1'b0;
        check("cmd_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [63:0] w, input logic last, input int gap);
        bus.in_isReady = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_data    = w;
        tb_last_word   = last;
        bus.in_isReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_canReceive) begin
                @(posedge clk); #1;
                bus.in_isReady = 1'b0;
                tb_last_word   = 1'b0;
                return;
            end
        end
        bus.in_isReady = 1'b0;
        tb_last_word   = 1'b0;
        check("word_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("drain_queue_empty", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output sink: always ready, or toggling every cycle
    always @(posedge clk) begin
        #1;
        if (sink_toggle) bus.out_canReceive = ~bus.out_canReceive;
        else             bus.out_canReceive = 1'b1;
    end

    // Monitor: scoreboard pop, hold-while-stalled, in_isLast_out relation, valid-run length
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_isReady), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(prev_out));
            end
            if (bus.in_isReady && bus.in_canReceive) begin
                check("in_isLast_out_xfer", 64'(bus.in_isLast_out), 64'(tb_last_word));
                if (bus.in_isLast_out) in_last_cnt++;
            end else begin
                check("in_isLast_out_idle", 64'(bus.in_isLast_out), 64'd0);
            end
            if (bus.out_isReady) run++;
            else                 run = 0;
            if (run > max_run) max_run = run;
            if (bus.out_isReady && bus.out_canReceive) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_data), 64'hDEAD);
                end else begin
                    mon_e = q.pop_front();
                    check("coeff", 64'(bus.out_data), 64'(mon_e.coeff));
                    check("out_isLast", 64'(bus.out_isLast), 64'(mon_e.last));
                    if (bus.out_isLast) out_last_cnt++;
                end
            end
            prev_stall = bus.out_isReady && !bus.out_canReceive;
            prev_out   = bus.out_data;
        end else begin
            prev_stall = 1'b0;
            run        = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        bus.cmd          = '0;
        bus.cmd_isReady  = 1'b0;
        bus.in_data      = '0;
        bus.in_isReady   = 1'b0;
        bus.in_isLast_in = 1'b0;

        // Reset state and first cycle after release
        repeat (2) @(negedge clk);
        check("rst_cmd_canReceive", 64'(bus.cmd_canReceive), 64'd0);
        check("rst_in_canReceive", 64'(bus.in_canReceive), 64'd0);
        check("rst_out_isReady", 64'(bus.out_isReady), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_isLast", 64'(bus.out_isLast), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rel_cmd_canReceive", 64'(bus.cmd_canReceive), 64'd0);
        check("post_rel_out_isReady", 64'(bus.out_isReady), 64'd0);
        @(negedge clk);
        check("ready_cmd_canReceive", 64'(bus.cmd_canReceive), 64'd1);
        @(posedge clk); #1;

        // Test 1: logQ=15, two words
        in_last_cnt = 0; out_last_cnt = 0;
        push_exp(16'h7FFF, 1'b0); push_exp(16'h0002, 1'b0);
        push_exp(16'h7FFF, 1'b0); push_exp(16'h0001, 1'b0);
        push_exp(16'h0004, 1'b0); push_exp(16'h0003, 1'b0);
        push_exp(16'h0002, 1'b0); push_exp(16'h0001, 1'b1);
        send_cmd(4'd15, 12'd2);
        send_word(64'h8001_7FFF_0002_FFFF, 1'b0, 0);
        send_word(64'h0001_0002_0003_0004, 1'b1, 0);
        wait_drain();
        check("t1_in_last_cnt", 64'(in_last_cnt), 64'd1);
        check("t1_out_last_cnt", 64'(out_last_cnt), 64'd1);

        // Test 2: logQ=0 means unmasked
        in_last_cnt = 0; out_last_cnt = 0;
        push_exp(16'hABCD, 1'b0); push_exp(16'h0001, 1'b0);
        push_exp(16'h8000, 1'b0); push_exp(16'hFFFF, 1'b1);
        send_cmd(4'd0, 12'd1);
        send_word(64'hFFFF_8000_0001_ABCD, 1'b1, 0);
        wait_drain();
        check("t2_in_last_cnt", 64'(in_last_cnt), 64'd1);
        check("t2_out_last_cnt", 64'(out_last_cnt), 64'd1);

        // Test 3: zero-word command produces no activity
        in_last_cnt = 0; out_last_cnt = 0;
        bus.in_isReady = 1'b1;
        send_cmd(4'd7, 12'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_in_canReceive", 64'(bus.in_canReceive), 64'd0);
            check("t3_out_isReady", 64'(bus.out_isReady), 64'd0);
        end
        bus.in_isReady = 1'b0;
        @(posedge clk); #1;
        check("t3_in_last_cnt", 64'(in_last_cnt), 64'd0);
        check("t3_out_last_cnt", 64'(out_last_cnt), 64'd0);

        // Test 4: stalling sink, irregular source
        in_last_cnt = 0; out_last_cnt = 0;
        sink_toggle = 1'b1;
        send_cmd(4'd13, 12'd3);
        for (int k = 0; k < 3; k++) begin
            w = {32'($urandom), 32'($urandom)};
            push_word(w, 4'd13, k == 2);
            send_word(w, k == 2, int'($urandom_range(0, 2)));
        end
        wait_drain();
        sink_toggle = 1'b0;
        check("t4_in_last_cnt", 64'(in_last_cnt), 64'd1);
        check("t4_out_last_cnt", 64'(out_last_cnt), 64'd1);

        // Test 5: continuous flow, no refill bubble
        in_last_cnt = 0; out_last_cnt = 0; max_run = 0;
        repeat (2) @(posedge clk);
        #1;
        send_cmd(4'd0, 12'd4);
        for (int k = 0; k < 4; k++) begin
            w = {32'($urandom), 32'($urandom)};
            push_word(w, 4'd0, k == 3);
            send_word(w, k == 3, 0);
        end
        wait_drain();
        check("t5_max_run", 64'(max_run), 64'd16);
        check("t5_in_last_cnt", 64'(in_last_cnt), 64'd1);
        check("t5_out_last_cnt", 64'(out_last_cnt), 64'd1);

        // Test 6: reset mid-word, then a clean command
        in_last_cnt = 0; out_last_cnt = 0;
        send_cmd(4'd0, 12'd5);
        push_word(64'h1111_2222_3333_4444, 4'd0, 1'b0);
        send_word(64'h1111_2222_3333_4444, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_out_isReady", 64'(bus.out_isReady), 64'd0);
        check("t6_rst_out_data", 64'(bus.out_data), 64'd0);
        check("t6_rst_in_canReceive", 64'(bus.in_canReceive), 64'd0);
        check("t6_rst_cmd_canReceive", 64'(bus.cmd_canReceive), 64'd0);
        check("t6_rst_out_isLast", 64'(bus.out_isLast), 64'd0);
        check("t6_partial_popped", 64'(q.size()), 64'd2);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rel_cmd_canReceive", 64'(bus.cmd_canReceive), 64'd0);
        @(posedge clk); #1;
        push_exp(16'hCDEF, 1'b0); push_exp(16'h89AB, 1'b0);
        push_exp(16'h4567, 1'b0); push_exp(16'h0123, 1'b1);
        send_cmd(4'd0, 12'd1);
        send_word(64'h0123_4567_89AB_CDEF, 1'b1, 0);
        wait_drain();
        check("t6_in_last_cnt", 64'(in_last_cnt), 64'd1);
        check("t6_out_last_cnt", 64'(out_last_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
